// File: rtl/seg7_reader.sv
`timescale 1ns/1ps
// seg7_reader
//
// Recovers a hex digit from an active-low 7-segment pattern bus. The bus is
// asynchronous, so it passes through a two-flop synchroniser. A pattern is
// accepted only after the synchronised value has stayed the same for
// STABLE_CYCLES consecutive samples. Accepted legal glyphs update digit_out.
// When the accepted glyph differs from the previously accepted pattern, the
// block also emits a one-cycle digit_valid pulse and advances change_count.
// Accepted patterns that are not glyphs raise the invalid level.
//
// Optional feature macro: SEG7_READER_BLANK_EN
//   defined   : the all-off pattern 1111111 is accepted as "blank". It sets
//               blank, clears invalid and forgets the last accepted glyph.
//   undefined : the all-off pattern is treated as illegal; blank is tied to 0.
//
// Parameters
//   STABLE_CYCLES  identical synchronised samples needed to accept (2..255)
//   CHG_W          width of change_count
//
// Ports
//   clk           design clock
//   reset_n       asynchronous active-low reset
//   seg_in[0:6]   active-low segments a..g, asynchronous to clk
//   digit_out     last accepted legal digit
//   digit_valid   one-cycle pulse when digit_out takes a new accepted value
//   invalid       most recently accepted pattern is not a glyph
//   blank         most recently accepted pattern was all-off (macro only)
//   change_count  number of digit_valid pulses, modulo 2^CHG_W
module seg7_reader #(
   parameter int STABLE_CYCLES = 4,
   parameter int CHG_W         = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [0:6]       seg_in,
   output logic [3:0]       digit_out,
   output logic             digit_valid,
   output logic             invalid,
   output logic             blank,
   output logic [CHG_W-1:0] change_count
);

   typedef enum logic {SETTLING, STABLE} state_t;

   localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

   // Returns {legal, code} for an active-low pattern.
   function automatic logic [4:0] decode(input logic [0:6] p);
      case (p)
         7'b0000001: decode = {1'b1, 4'h0};
         7'b1001111: decode = {1'b1, 4'h1};
         7'b0010010: decode = {1'b1, 4'h2};
         7'b0000110: decode = {1'b1, 4'h3};
         7'b1001100: decode = {1'b1, 4'h4};
         7'b0100100: decode = {1'b1, 4'h5};
         7'b0100000: decode = {1'b1, 4'h6};
         7'b0001111: decode = {1'b1, 4'h7};
         7'b0000000: decode = {1'b1, 4'h8};
         7'b0000100: decode = {1'b1, 4'h9};
         7'b0001000: decode = {1'b1, 4'hA};
         7'b1100000: decode = {1'b1, 4'hB};
         7'b0110001: decode = {1'b1, 4'hC};
         7'b1000010: decode = {1'b1, 4'hD};
         7'b0110000: decode = {1'b1, 4'hE};
         7'b0111000: decode = {1'b1, 4'hF};
         default:    decode = 5'b0_0000;
      endcase
   endfunction

   logic [0:6]       s1, s2;
   logic [0:6]       cand_q, cand_d;
   logic [7:0]       cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic [0:6]       last_q, last_d;
   logic [3:0]       digit_d;
   logic             valid_d;
   logic             invalid_d;
   logic [CHG_W-1:0] count_d;
   logic             accept;
   logic [4:0]       dec;

`ifdef SEG7_READER_BLANK_EN
   logic blank_q, blank_d;
   assign blank = blank_q;
`else
   assign blank = 1'b0;
`endif

   // Next-state and output decision
   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      digit_d   = digit_out;
      valid_d   = 1'b0;
      invalid_d = invalid;
      count_d   = change_count;
      accept    = 1'b0;
      dec       = 5'b0_0000;
`ifdef SEG7_READER_BLANK_EN
      blank_d   = blank_q;
`endif

      // Any change at s2 restarts the stability count with this sample as #1.
      if (s2 != cand_q) begin
         cand_d  = s2;
         cnt_d   = 8'd1;
         state_d = SETTLING;
      end else if (state_q == SETTLING) begin
         if (cnt_q < LAST_CNT) begin
            cnt_d = cnt_q + 8'd1;
         end else begin
            accept  = 1'b1;
            state_d = STABLE;
         end
      end

      if (accept) begin
         dec = decode(cand_q);
         if (dec[4]) begin
            digit_d   = dec[3:0];
            invalid_d = 1'b0;
`ifdef SEG7_READER_BLANK_EN
            blank_d   = 1'b0;
`endif
            // Only a change against the last accepted pattern is news.
            if (cand_q != last_q) begin
               valid_d = 1'b1;
               count_d = change_count + CHG_W'(1);
            end
            last_d = cand_q;
         end
`ifdef SEG7_READER_BLANK_EN
         else if (cand_q == 7'b1111111) begin
            // Blank forgets the last digit so a repeat after it is reported.
            blank_d   = 1'b1;
            invalid_d = 1'b0;
            last_d    = 7'b1111111;
         end
`endif
         else begin
            invalid_d = 1'b1;
`ifdef SEG7_READER_BLANK_EN
            blank_d   = 1'b0;
`endif
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1           <= 7'b1111111;
         s2           <= 7'b1111111;
         cand_q       <= 7'b1111111;
         cnt_q        <= 8'd0;
         state_q      <= SETTLING;
         last_q       <= 7'b1111111;
         digit_out    <= 4'h0;
         digit_valid  <= 1'b0;
         invalid      <= 1'b0;
         change_count <= '0;
`ifdef SEG7_READER_BLANK_EN
         blank_q      <= 1'b0;
`endif
      end else begin
         s1           <= seg_in;
         s2           <= s1;
         cand_q       <= cand_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         last_q       <= last_d;
         digit_out    <= digit_d;
         digit_valid  <= valid_d;
         invalid      <= invalid_d;
         change_count <= count_d;
`ifdef SEG7_READER_BLANK_EN
         blank_q      <= blank_d;
`endif
      end
   end

endmodule
